iob_rr_arb: RTL and testbench
=============================

IOB_RR_ARB -- requirements
Module: iob_rr_arb

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4, meaning the number of IOb master ports (2..16).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the watchdog limit in cycles, used only under IOB_ARB_TIMEOUT_EN.
REQ-005 SHALL have the ports below; there is one clock, and reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- m_valid  in  N_MASTERS  per-master request
- m_addr  in  N_MASTERS*ADDR_W  flattened; master i at slice i
- m_wdata  in  N_MASTERS*DATA_W  flattened write data
- m_wstrb  in  N_MASTERS*DATA_W/8  flattened strobes; 0 means read
- m_rdata  out  DATA_W  read data, shared by all masters
- m_rvalid  out  N_MASTERS  per-master read-data valid
- m_ready  out  N_MASTERS  per-master request accepted
- s_valid, s_addr, s_wdata, s_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  shared slave request
- s_rdata  in  DATA_W  slave read data
- s_rvalid  in  1  slave read-data valid
- s_ready  in  1  slave accepted the request
- grant_idx  out  $clog2(N_MASTERS)  index of the current or last granted master

Function
REQ-006 SHALL implement a three-state FSM: IDLE, REQ and RESP.
REQ-007 In IDLE, when any m_valid is set, the block SHALL register the round-robin winner. The winner is the first requesting index above ptr, wrapping around. The FSM moves to REQ, and ptr and grant_idx take the winner's index.
REQ-008 The s_valid output SHALL rise exactly 1 cycle after the cycle in which the winner's m_valid was sampled in IDLE.
REQ-009 In REQ, s_valid SHALL be 1, and s_addr, s_wdata and s_wstrb SHALL be combinationally muxed from the granted master.
REQ-010 In REQ, m_ready[grant_idx] SHALL equal s_ready.
REQ-011 In REQ, when s_ready is high and s_wstrb is not 0, the FSM SHALL move to IDLE. When s_ready is high and s_wstrb is 0, it SHALL move to RESP.
REQ-012 When s_ready and s_rvalid are both high in the same REQ cycle, the read SHALL complete immediately: m_rvalid[grant_idx] is set and the FSM moves to IDLE.
REQ-013 In RESP, m_rvalid[grant_idx] SHALL equal s_rvalid, and on s_rvalid the FSM SHALL move to IDLE.
REQ-014 The m_rdata output SHALL equal s_rdata at all times.
REQ-015 Non-granted masters SHALL see m_ready=0 and m_rvalid=0 at all times.
REQ-016 In IDLE, s_valid SHALL be 0; s_addr, s_wdata and s_wstrb SHALL hold their last-muxed values.
REQ-017 A master dropping m_valid while in REQ SHALL NOT abort the transaction; masters are required to hold m_valid until m_ready.
REQ-018 There SHALL be no back-to-back bypass: at least one IDLE cycle separates transactions.
REQ-019 Master i's worst-case wait SHALL be N_MASTERS-1 transactions.

Reset
REQ-020 Asserting rst SHALL force state=IDLE, ptr=N_MASTERS-1 (so master 0 wins first), grant_idx=0, and all of m_ready, m_rvalid and s_valid to 0, including mid-transaction.
REQ-021 A transaction interrupted by rst SHALL be dropped without retry.

Configuration
REQ-022 With macro IOB_ARB_TIMEOUT_EN defined, the block SHALL add a sticky output timeout_err (1 bit) and a cycle counter.
- The counter clears on entry to REQ and counts in REQ and RESP.
- When the counter reaches TIMEOUT-1, the block pulses m_ready (if in REQ) and m_rvalid (if a read) to the granted master for 1 cycle.
- During that pulse, m_rdata={DATA_W{1'b1}}.
- The FSM then returns to IDLE and timeout_err is set; only rst clears it.
REQ-023 Without IOB_ARB_TIMEOUT_EN, the timeout_err port and the counter SHALL NOT exist, and REQ and RESP SHALL wait indefinitely.

Structure
REQ-024 Package iob_rr_arb_pkg SHALL hold the FSM state typedef (IDLE/REQ/RESP) and the constant-width helper.
REQ-025 Winner selection SHALL be a separate combinational sub-module, iob_rr_arb_sel, with inputs request and ptr and outputs valid and index.

Verification
REQ-026 After reset, m_valid=4'b1111 held, all writes, s_ready=1 → grant order SHALL be 0,1,2,3,0, with each s_valid 1 cycle after IDLE sampling.
REQ-027 Master 2 reads 0x100, s_ready at cycle 1 and s_rvalid=1 with s_rdata=0xCAFEF00D at cycle 3 → m_rvalid[2] SHALL pulse once with that data, and no other m_rvalid bit SHALL be set.
REQ-028 Read with s_ready and s_rvalid in the same cycle → the FSM SHALL skip RESP, and m_ready[g] and m_rvalid[g] SHALL assert together.
REQ-029 rst asserted in RESP, then m_valid[1] only → s_valid SHALL drop asynchronously, and the next grant SHALL go to master 1 with ptr logic restarted from 0.
REQ-030 IOB_ARB_TIMEOUT_EN, TIMEOUT=16, s_ready stuck 0 → m_ready[g] SHALL pulse at cycle 16 after REQ entry, timeout_err=1, and the next requester SHALL be granted.

Source files
------------

// File: rtl/iob_rr_arb_pkg.sv
// Shared types and helpers for the round-robin IOb arbiter.
package iob_rr_arb_pkg;

  // Arbiter FSM: idle, request phase on the slave, waiting for read data.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  // Index width for n ports; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_arb_sel.sv
// Round-robin winner select: first requesting index above ptr, wrapping around.
module iob_rr_arb_sel
  import iob_rr_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         request,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic                 valid,
  output logic [idx_w(N)-1:0]  index
);

  localparam int unsigned IdxW = idx_w(N);

  int pos;

  // Scan from the farthest offset down so the nearest requester above ptr wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int k = int'(N); k >= 1; k--) begin
      pos = (int'(ptr) + k) % int'(N);
      if (request[pos]) begin
        valid = 1'b1;
        index = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/iob_rr_arb.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS masters.
// Optional watchdog enabled by defining IOB_ARB_TIMEOUT_EN (adds timeout_err).
module iob_rr_arb
  import iob_rr_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic [N_MASTERS-1:0]            m_rvalid,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic                            s_valid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata,
  input  logic                            s_rvalid,
  input  logic                            s_ready,
  output logic [idx_w(N_MASTERS)-1:0]     grant_idx
`ifdef IOB_ARB_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  localparam int unsigned IdxW  = idx_w(N_MASTERS);
  localparam int unsigned StrbW = DATA_W / 8;

  if (N_MASTERS < 2 || N_MASTERS > 16) begin : g_bad_masters
    $error("iob_rr_arb: N_MASTERS must be 2..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("iob_rr_arb: TIMEOUT must be at least 2");
  end

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic              sel_valid;
  logic [IdxW-1:0]   sel_idx;

  logic [ADDR_W-1:0] mux_addr, hold_addr_q;
  logic [DATA_W-1:0] mux_wdata, hold_wdata_q;
  logic [StrbW-1:0]  mux_wstrb, hold_wstrb_q;
  logic              is_read;
  logic              tmo;

  iob_rr_arb_sel #(
    .N(N_MASTERS)
  ) u_sel (
    .request(m_valid),
    .ptr    (ptr_q),
    .valid  (sel_valid),
    .index  (sel_idx)
  );

  // Select the granted master's request fields.
  always_comb begin
    mux_addr  = '0;
    mux_wdata = '0;
    mux_wstrb = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (grant_q == IdxW'(i)) begin
        mux_addr  = m_addr[i*ADDR_W +: ADDR_W];
        mux_wdata = m_wdata[i*DATA_W +: DATA_W];
        mux_wstrb = m_wstrb[i*StrbW +: StrbW];
      end
    end
  end

  assign is_read = (mux_wstrb == '0);

`ifdef IOB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  assign tmo         = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT - 1));
  assign timeout_err = err_q;

  // Watchdog counter: held at zero in idle so it starts from zero on REQ entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) cnt_q <= '0;
      else                   cnt_q <= cnt_q + 1'b1;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state and per-master handshake decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    m_ready  = '0;
    m_rvalid = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d = StReq;
          ptr_d   = sel_idx;
          grant_d = sel_idx;
        end
      end
      StReq: begin
        if (tmo) begin
          // Watchdog releases the master with a forced handshake.
          m_ready[grant_q] = 1'b1;
          if (is_read) m_rvalid[grant_q] = 1'b1;
          state_d = StIdle;
        end else if (s_ready) begin
          m_ready[grant_q] = 1'b1;
          if (!is_read) begin
            state_d = StIdle;
          end else if (s_rvalid) begin
            m_rvalid[grant_q] = 1'b1;
            state_d           = StIdle;
          end else begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (tmo || s_rvalid) begin
          m_rvalid[grant_q] = 1'b1;
          state_d           = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign grant_idx = grant_q;
  assign s_valid   = (state_q == StReq);
  assign s_addr    = s_valid ? mux_addr  : hold_addr_q;
  assign s_wdata   = s_valid ? mux_wdata : hold_wdata_q;
  assign s_wstrb   = s_valid ? mux_wstrb : hold_wstrb_q;
  assign m_rdata   = tmo ? {DATA_W{1'b1}} : s_rdata;

  // State, pointer and grant registers; slave fields are captured while in REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= IdxW'(N_MASTERS - 1);
      grant_q      <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      if (state_q == StReq) begin
        hold_addr_q  <= mux_addr;
        hold_wdata_q <= mux_wdata;
        hold_wstrb_q <= mux_wstrb;
      end
    end
  end

endmodule

// File: tb/tb_iob_rr_arb.sv
// Randomized self-checking bench for iob_rr_arb with a transaction-level model.
// Timeout scenario is exercised when IOB_ARB_TIMEOUT_EN is defined.
module tb_iob_rr_arb;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_rvalid;
  logic            s_ready;
  logic [1:0]      grant_idx;
`ifdef IOB_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  iob_rr_arb #(
    .N_MASTERS(N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_valid  (m_valid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .m_ready  (m_ready),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid),
    .s_ready  (s_ready),
    .grant_idx(grant_idx)
`ifdef IOB_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  // Master-side request book: a pending request holds its payload until m_ready.
  bit          pend [N];
  logic [31:0] p_addr [N];
  logic [31:0] p_wdata [N];
  logic [3:0]  p_wstrb [N];

  int  p_req      = 0;
  bit  wr_only    = 0;
  bit  drop_en    = 0;
  bit  rand_slave = 0;
  int  p_ready    = 50;
  int  p_rvalid   = 50;
  logic        nxt_ready  = 0;
  logic        nxt_rvalid = 0;
  logic [31:0] nxt_rdata  = 0;

  // Reference model: bus phase 0 = free, 1 = address phase, 2 = awaiting read data.
  int          ph, mptr, mgrant, tcnt;
  bit          terr, h_known;
  logic [31:0] h_addr, h_wdata;
  logic [3:0]  h_wstrb;
  int          grants[$];

  // Observations used by directed scenarios.
  int          rv_cnt [N];
  logic [31:0] rv_data [N];
  int          same_cnt;
  logic [N-1:0] obs_ready;

  task automatic model_reset();
    ph = 0; mptr = N - 1; mgrant = 0; tcnt = 0; terr = 0; h_known = 0;
    h_addr = 0; h_wdata = 0; h_wstrb = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < N; i++) begin rv_cnt[i] = 0; rv_data[i] = 0; end
    same_cnt = 0;
  endtask

  task automatic post(input int i, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    pend[i] = 1; p_addr[i] = a; p_wdata[i] = d; p_wstrb[i] = s;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && p_req > 0 && $urandom_range(99) < p_req) begin
        pend[i] = 1; p_addr[i] = $urandom; p_wdata[i] = $urandom;
        if (wr_only || $urandom_range(1) == 1) p_wstrb[i] = 4'($urandom_range(15, 1));
        else p_wstrb[i] = 4'd0;
      end
      m_valid[i] = pend[i] && !(drop_en && $urandom_range(3) == 0);
      m_addr[i*AW +: AW]  = pend[i] ? p_addr[i]  : $urandom;
      m_wdata[i*DW +: DW] = pend[i] ? p_wdata[i] : $urandom;
      m_wstrb[i*SW +: SW] = pend[i] ? p_wstrb[i] : 4'($urandom);
    end
    if (rand_slave) begin
      s_ready  = ($urandom_range(99) < p_ready);
      s_rvalid = ($urandom_range(99) < p_rvalid);
      s_rdata  = $urandom;
    end else begin
      s_ready = nxt_ready; s_rvalid = nxt_rvalid; s_rdata = nxt_rdata;
    end
  endtask

  // Compare DUT outputs against the model for this cycle, then advance the model.
  task automatic check_step();
    logic [N-1:0] er, ev;
    logic [31:0]  ga, gd, erd;
    logic [3:0]   gs;
    bit           rd, tout;
    int           w;
    er = '0; ev = '0; erd = s_rdata;
    ga = m_addr[mgrant*AW +: AW];
    gd = m_wdata[mgrant*DW +: DW];
    gs = m_wstrb[mgrant*SW +: SW];
    rd = (gs == 4'd0);
    tout = 0;
`ifdef IOB_ARB_TIMEOUT_EN
    tout = (ph != 0) && (tcnt == TMO - 1);
`endif
    if (ph == 1) begin
      if (tout) begin er[mgrant] = 1; if (rd) ev[mgrant] = 1; erd = '1; end
      else if (s_ready) begin er[mgrant] = 1; if (rd && s_rvalid) ev[mgrant] = 1; end
    end else if (ph == 2) begin
      if (tout) begin ev[mgrant] = 1; erd = '1; end
      else if (s_rvalid) ev[mgrant] = 1;
    end

    check("s_valid", s_valid, ph == 1);
    check("grant_idx", grant_idx, mgrant);
    check("m_ready", m_ready, er);
    check("m_rvalid", m_rvalid, ev);
    check("m_rdata", m_rdata, erd);
    if (ph == 1) begin
      check("s_addr", s_addr, ga);
      check("s_wdata", s_wdata, gd);
      check("s_wstrb", s_wstrb, gs);
    end else if (h_known) begin
      check("s_addr_hold", s_addr, h_addr);
      check("s_wdata_hold", s_wdata, h_wdata);
      check("s_wstrb_hold", s_wstrb, h_wstrb);
    end
`ifdef IOB_ARB_TIMEOUT_EN
    check("timeout_err", timeout_err, terr);
`endif

    obs_ready = m_ready;
    for (int i = 0; i < N; i++) begin
      if (m_rvalid[i]) begin rv_cnt[i]++; rv_data[i] = m_rdata; end
      if (m_rvalid[i] && m_ready[i]) same_cnt++;
    end

    if (ph == 0) begin
      if (m_valid != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && m_valid[(mptr + k) % N]) w = (mptr + k) % N;
        end
        ph = 1; mptr = w; mgrant = w; tcnt = 0;
        grants.push_back(w);
      end
    end else begin
      if (ph == 1) begin
        h_addr = ga; h_wdata = gd; h_wstrb = gs; h_known = 1;
      end
      tcnt++;
      if (tout) begin
        ph = 0; terr = 1;
      end else if (ph == 1 && s_ready) begin
        ph = (rd && !s_rvalid) ? 2 : 0;
      end else if (ph == 2 && s_rvalid) begin
        ph = 0;
      end
    end
    for (int i = 0; i < N; i++) if (er[i]) pend[i] = 0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
    drive_inputs();
    @(negedge clk);
    check_step();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    p_req = 0; drop_en = 0; rand_slave = 0;
    nxt_ready = 1; nxt_rvalid = 1;
    for (int c = 0; c < 100 && !done; c++) begin
      cycle();
      done = (ph == 0);
      for (int i = 0; i < N; i++) if (pend[i]) done = 0;
    end
    check("drain", done, 1);
    nxt_ready = 0; nxt_rvalid = 0;
  endtask

  // Assert reset between edges and check the outputs drop without a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_s_valid"}, s_valid, 0);
    check({tag, "_m_ready"}, m_ready, 0);
    check({tag, "_m_rvalid"}, m_rvalid, 0);
    check({tag, "_grant"}, grant_idx, 0);
`ifdef IOB_ARB_TIMEOUT_EN
    check({tag, "_terr"}, timeout_err, 0);
`endif
    model_reset();
    m_valid = '0;
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_ord[5];
    int n;
    bit seen;
    rst = 1'b1;
    m_valid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_rdata = '0; s_rvalid = 0; s_ready = 0;
    model_reset();
    clear_obs();

    // Reset values.
    @(negedge clk);
    check("rst_s_valid", s_valid, 0);
    check("rst_m_ready", m_ready, 0);
    check("rst_m_rvalid", m_rvalid, 0);
    check("rst_grant", grant_idx, 0);
    #1 rst = 1'b0;

    // All four masters writing back to back with s_ready held high.
    exp_ord = '{0, 1, 2, 3, 0};
    grants.delete();
    p_req = 100; wr_only = 1; nxt_ready = 1;
    for (int c = 0; c < 12; c++) cycle();
    check("rr_count", grants.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grants.size(); k++) check("rr_order", grants[k], exp_ord[k]);
    wr_only = 0;
    drain();

    // Master 2 read: s_ready one cycle after REQ entry, data two cycles later.
    clear_obs();
    nxt_ready = 0; nxt_rvalid = 0;
    post(2, 32'h100, 32'h0, 4'h0);
    cycle();
    cycle();
    nxt_ready = 1;
    cycle();
    nxt_ready = 0;
    cycle();
    nxt_rvalid = 1; nxt_rdata = 32'hCAFEF00D;
    cycle();
    nxt_rvalid = 0; nxt_rdata = 32'h0;
    for (int c = 0; c < 3; c++) cycle();
    check("rd2_pulses", rv_cnt[2], 1);
    check("rd2_data", rv_data[2], 32'hCAFEF00D);
    check("rd_others", rv_cnt[0] + rv_cnt[1] + rv_cnt[3], 0);

    // Read completed in the address phase.
    clear_obs();
    post(0, 32'h40, 32'h0, 4'h0);
    nxt_ready = 1; nxt_rvalid = 1; nxt_rdata = 32'h1234_5678;
    for (int c = 0; c < 4; c++) cycle();
    check("fast_rd_same", same_cnt, 1);
    check("fast_rd_data", rv_data[0], 32'h1234_5678);
    drain();

    // Reset in REQ and in RESP, then master 1 alone requests.
    post(3, 32'h200, 32'h0, 4'h0);
    nxt_ready = 0;
    cycle();
    cycle();
    async_reset("rst_req");
    post(3, 32'h300, 32'h0, 4'h0);
    nxt_ready = 1;
    cycle();
    cycle();
    nxt_ready = 0;
    cycle();
    s_rvalid = 1'b1;
    async_reset("rst_resp");
    post(1, 32'h10, 32'hA5A5_5A5A, 4'hF);
    nxt_ready = 1; nxt_rvalid = 0;
    grants.delete();
    cycle();
    cycle();
    check("post_rst_grant", grant_idx, 1);
    check("post_rst_first", grants.size() > 0 ? grants[0] : -1, 1);
    drain();

    // Randomized traffic with varying slave responsiveness.
    rand_slave = 1; drop_en = 1;
    for (int seg = 0; seg < 3; seg++) begin
      p_req    = 10 + 30 * seg;
      p_ready  = (seg == 0) ? 100 : (seg == 1) ? 60 : 25;
      p_rvalid = (seg == 2) ? 30 : 70;
      for (int c = 0; c < 1000; c++) cycle();
    end
    drain();

    // Slave never accepts: watchdog release or indefinite wait.
    post(1, 32'h80, 32'h1, 4'h3);
    post(2, 32'h84, 32'h2, 4'h3);
    nxt_ready = 0; nxt_rvalid = 0;
    cycle();
    n = 0; seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle();
      n++;
      seen = obs_ready[1];
    end
`ifdef IOB_ARB_TIMEOUT_EN
    check("tmo_seen", seen, 1);
    check("tmo_cycle", n, TMO);
    check("tmo_err", timeout_err, 1);
    cycle();
    cycle();
    check("tmo_next_grant", grant_idx, 2);
`else
    check("no_tmo_ready", seen, 0);
    check("no_tmo_s_valid", s_valid, 1);
    check("no_tmo_grant", grant_idx, 1);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
